seq_divider: RTL and testbench
==============================

# seq_divider

Iterative restoring divider: the inverse of the team's registered 8×8 multiplier. It takes a 16-bit dividend (typically a registered product) and an 8-bit divisor. It produces a 16-bit quotient and an 8-bit remainder after one shift-subtract step per clock, using a start/busy/done handshake. It sits between the switch/key input registers and the hex-display decoders, so a product can be divided back down.

## Interface
- N, default 16: dividend and quotient width; equals iteration count.
- D, default 8: divisor and remainder width.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (clears all state when 0).
- start  input  1  request; sampled only when accepting (IDLE or DONE).
- dividend  input  N  numerator, latched on accepted start.
- divisor  input  D  denominator, latched on accepted start.
- busy  output  1  high while a division is in progress (RUN).
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- dbz  output  1  divide-by-zero flag, valid with done, held until next accepted start.
- quotient  output  N  result, registered, held until next completion.
- remainder  output  D  result, registered, held until next completion.

## Operation
- States:
  - IDLE: waiting.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- IDLE/DONE + start=1:
  - Latch dividend into shift register Q and divisor into M.
  - Clear partial remainder R (D+1 bits) and iteration counter.
  - If divisor==0, go to DONE directly with dbz=1, quotient=all ones, remainder=0.
  - Otherwise go to RUN.
- IDLE/DONE + start=0: go to (or stay in) IDLE.
- RUN step, one per clock:
  - R' = {R[D-1:0], Q[N-1]}.
  - Q' = {Q[N-2:0], 0}.
  - If R' ≥ M: R' = R' − M and Q'[0] = 1.
  - Counter increments.
  - After the N-th step: go to DONE, load quotient=Q', remainder=R'[D-1:0], dbz=0.
- start during RUN is ignored; latched operands are unaffected by input changes after acceptance.
- All arithmetic is unsigned. R needs D+1 bits, so a shifted-in value up to 2·M−1 compares correctly.
- dividend < divisor: quotient 0, remainder = dividend[D-1:0]. This still takes the full N steps.

## Timing
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, dbz=0, quotient=0, remainder=0, counter=0.
- reset asserted mid-RUN aborts immediately. Nothing is reported afterwards; the first accepted start after release begins fresh.
- Start accepted at edge k:
  - busy=1 from after edge k through edge k+N.
  - done=1 for exactly the cycle after edge k+N, i.e. latency N clocks (16 by default).
  - busy=0 during the done cycle.
- Divide-by-zero: done=1 in the cycle after edge k (latency 1); busy never asserts.
- Back-to-back: start=1 during the done cycle is accepted. Peak throughput is one division per N+1 clocks.
- quotient, remainder and dbz change only on the edge that enters DONE (or on reset).

## Structure
- Package seq_divider_pkg holds:
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default widths N=16 and D=8.
  - Counter width $clog2(N+1).
- Sub-module div_step: combinational single restoring step.
  - Inputs: R, Q, M.
  - Outputs: R', Q'.
  - Instantiated once in the datapath; reused by the bench as a reference model.
- Top-level board wiring (switches, keys, hex decoders) stays outside this block.

## Test plan
- 1000 / 7, start at edge k: busy high for 16 cycles, then done pulse at k+16 with quotient=142, remainder=6, dbz=0.
- 65535 / 255: quotient=257, remainder=0. 5 / 9: quotient=0, remainder=5, full 16-cycle latency.
- 1234 / 0: done in the cycle after start, dbz=1, quotient=16'hFFFF, remainder=0, busy stays 0.
- start re-pulsed with new operands during RUN: ignored; original result 1000/7 delivered at the original cycle.
- reset pulsed low at step 8 of 300/4: outputs zero immediately, no done pulse. The next start of 300/4 yields 75 r 0 after 16 cycles.
- start held high continuously with 200/3: done every 17 cycles, each 66 r 2. Outputs hold between pulses.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the iterative restoring divider: state encoding and default widths.
package seq_divider_pkg;

    localparam int N_DEF = 16;
    localparam int D_DEF = 8;
    localparam int CNT_W = $clog2(N_DEF + 1);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_divider_if #(
    parameter int N = 16,
    parameter int D = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, dbz, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, dbz, quotient, remainder
    );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring shift-subtract step.
module div_step #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic [D-1:0] r_i,
    input  logic [N-1:0] q_i,
    input  logic [D-1:0] m_i,
    output logic [D-1:0] r_o,
    output logic [N-1:0] q_o
);
    logic [D:0] r_sh;
    logic [D:0] m_ext;
    logic [D:0] r_sub;

    // The incoming remainder is always < M, so only the shifted value needs the extra bit.
    assign r_sh  = {r_i, q_i[N-1]};
    assign m_ext = {1'b0, m_i};
    assign r_sub = r_sh - m_ext;

    always_comb begin
        q_o = {q_i[N-2:0], 1'b0};
        r_o = r_sh[D-1:0];
        if (r_sh >= m_ext) begin
            q_o[0] = 1'b1;
            r_o    = r_sub[D-1:0];
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: N-bit dividend / D-bit divisor, one step per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  dv
);
    localparam int CW = $clog2(N + 1);

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [D-1:0] m_q, m_d;
    logic [D-1:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] quot_q, quot_d;
    logic [D-1:0] rem_q, rem_d;
    logic         dbz_q, dbz_d;

    logic [D-1:0] r_step;
    logic [N-1:0] q_step;

    div_step #(.N(N), .D(D)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .m_i (m_q),
        .r_o (r_step),
        .q_o (q_step)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        m_d     = m_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (dv.start) begin
                    q_d   = dv.dividend;
                    m_d   = dv.divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    // Zero divisor short-circuits straight to the result cycle.
                    if (dv.divisor == '0) begin
                        state_d = ST_DONE;
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign dv.busy      = (state_q == ST_RUN);
    assign dv.done      = (state_q == ST_DONE);
    assign dv.dbz       = dbz_q;
    assign dv.quotient  = quot_q;
    assign dv.remainder = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency/handshake model checked every cycle plus literal results.
module tb_seq_divider;
    localparam int N = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.N(N), .D(D)) dv ();

    seq_divider #(.N(N), .D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .dv    (dv)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: result from / and %, visible N edges after acceptance.
    logic         m_busy, m_done, m_dbz;
    logic [N-1:0] m_q, p_q;
    logic [D-1:0] m_r, p_r;
    int           left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0; left <= 0;
        end else if (left != 0) begin
            left <= left - 1;
            if (left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_dbz <= 1'b0;
                m_q <= p_q; m_r <= p_r;
            end else begin
                m_done <= 1'b0;
            end
        end else if (dv.start) begin
            if (dv.divisor == '0) begin
                m_done <= 1'b1; m_dbz <= 1'b1; m_q <= '1; m_r <= '0;
            end else begin
                m_done <= 1'b0; m_busy <= 1'b1; left <= N;
                p_q <= N'(dv.dividend / dv.divisor);
                p_r <= D'(dv.dividend % dv.divisor);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(dv.busy), 32'(m_busy));
        chk("done", 32'(dv.done), 32'(m_done));
        chk("dbz", 32'(dv.dbz), 32'(m_dbz));
        chk("quotient", 32'(dv.quotient), 32'(m_q));
        chk("remainder", 32'(dv.remainder), 32'(m_r));
    end

    // Launch one division; j counts edges after the accepting edge, sampled at negedges.
    task automatic run(input logic [N-1:0] a, input logic [D-1:0] b, input logic [N-1:0] eq,
                       input logic [D-1:0] er, input logic edbz, input int ej, input bit poke);
        int j;
        bit seen;
        dv.start = 1'b1; dv.dividend = a; dv.divisor = b;
        @(negedge clk);
        j = 0; seen = 1'b0;
        dv.start = 1'b0; dv.dividend = 16'hDEAD; dv.divisor = 8'h11;
        while (!seen && j <= 40) begin
            if (dv.done) begin
                seen = 1'b1;
            end else begin
                if (j == 1) chk("busy_lit", 32'(dv.busy), 32'(1));
                if (poke && j == 5) begin
                    dv.start = 1'b1; dv.dividend = 16'd999; dv.divisor = 8'd3;
                end
                if (poke && j == 6) dv.start = 1'b0;
                @(negedge clk);
                j++;
            end
        end
        chk("done_seen", 32'(seen), 32'(1));
        chk("latency", 32'(j), 32'(ej));
        chk("q_lit", 32'(dv.quotient), 32'(eq));
        chk("r_lit", 32'(dv.remainder), 32'(er));
        chk("dbz_lit", 32'(dv.dbz), 32'(edbz));
        chk("busy_in_done", 32'(dv.busy), 32'(0));
    endtask

    initial begin
        int j;
        int nd;
        int dj[3];
        dv.start = 1'b0; dv.dividend = '0; dv.divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(dv.busy), 32'(0));
        chk("rst_done", 32'(dv.done), 32'(0));
        chk("rst_q", 32'(dv.quotient), 32'(0));
        chk("rst_r", 32'(dv.remainder), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        run(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1'b0);
        run(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 1'b0);
        run(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16, 1'b0);
        run(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 0, 1'b0);
        run(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1'b1);

        // Abort mid-run with reset; nothing may be reported afterwards.
        dv.start = 1'b1; dv.dividend = 16'd300; dv.divisor = 8'd4;
        @(negedge clk);
        dv.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(dv.busy), 32'(0));
        chk("abort_q", 32'(dv.quotient), 32'(0));
        chk("abort_r", 32'(dv.remainder), 32'(0));
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (20) @(negedge clk);
        run(16'd300, 8'd4, 16'd75, 8'd0, 1'b0, 16, 1'b0);

        // start held high: back-to-back results every N+1 clocks.
        dv.start = 1'b1; dv.dividend = 16'd200; dv.divisor = 8'd3;
        @(negedge clk);
        j = 0; nd = 0;
        while (nd < 3 && j < 80) begin
            if (dv.done) begin
                dj[nd] = j;
                chk("cont_q", 32'(dv.quotient), 32'(66));
                chk("cont_r", 32'(dv.remainder), 32'(2));
                nd++;
            end
            if (nd < 3) begin
                @(negedge clk);
                j++;
            end
        end
        dv.start = 1'b0;
        chk("cont_count", 32'(nd), 32'(3));
        if (nd == 3) begin
            chk("cont_first", 32'(dj[0]), 32'(16));
            chk("cont_gap1", 32'(dj[1] - dj[0]), 32'(17));
            chk("cont_gap2", 32'(dj[2] - dj[1]), 32'(17));
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
